decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Decode/issue stage directly upstream of the 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads an internal 8x16 register file (write port driven by writeback) and tracks pending writers with a scoreboard.
- Presents registered operands, func4, imm and imm_en to the execute stage through a valid/ready output register.

Parameters:
XLEN, 16, datapath and register width
NREGS, 8, architectural registers; fixed by 3-bit register fields

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
instr_valid_i  in  1  instruction present
instr_ready_o  out  1  stage accepts instruction this cycle
instr_i  in  16  instruction word
wb_en_i  in  1  writeback write enable
wb_rd_i  in  3  writeback destination
wb_data_i  in  16  writeback data
ex_valid_o  out  1  output register holds an issued instruction
ex_ready_i  in  1  execute stage consumes this cycle
rs1_data_o  out  16  operand A
rs2_data_o  out  16  operand B register value
imm_o  out  16  sign-extended immediate
imm_en_o  out  1  select imm as operand B
func4_o  out  4  ALU op code, passed through unmodified (interpreted as alu_src_t)
rd_o  out  3  destination register
rd_wr_o  out  1  instruction writes back (rd != 0)

Behaviour:
- Instruction format:
  - [15] imm_en; [14:11] func4; [10:8] rd; [7:5] rs1.
  - R-form: [4:2] rs2, [1:0] ignored.
  - I-form: [4:0] imm5, sign-extended to 16 bits.
  - imm_o is always imm5 sign-extended, regardless of imm_en.
- Register file:
  - r0 reads 0; writes to r0 are ignored.
  - Write occurs on a clock edge when wb_en_i=1.
  - Read bypass: if wb_en_i=1, wb_rd_i!=0 and wb_rd_i matches the read address in the same cycle, the read returns wb_data_i.
- Scoreboard: busy[7:0], busy[0] always 0.
  - Set busy[rd] on issue when rd != 0.
  - Clear busy[wb_rd_i] on wb_en_i.
  - Same-cycle set and clear of the same register: set wins.
- Hazard stall. An operand register r is "pending" iff busy[r]=1 and !(wb_en_i && wb_rd_i==r). Stall when any of:
  - rs1 is pending;
  - imm_en=0 and rs2 is pending;
  - rd != 0 and rd is pending (WAW).
- Handshake:
  - instr_ready_o = !stall && (!ex_valid_o || ex_ready_i); stall is evaluated on instr_i.
  - instr_ready_o may depend combinationally on instr_i; instr_valid_i must not depend on instr_ready_o.
  - Issue = instr_valid_i && instr_ready_o.
- Output register:
  - On issue, all ex_* payload outputs load the decoded fields and bypassed read data, and ex_valid_o<=1.
  - Otherwise, if ex_ready_i, ex_valid_o<=0.
  - While ex_valid_o && !ex_ready_i, all outputs hold stable.
  - Back-to-back issue at one instruction per cycle when no hazards.
- Latency: instruction accepted at edge N is on the outputs after edge N. Operand values are those visible at issue, including any same-cycle writeback.
- Reset (async, any time, including mid-stall): ex_valid_o=0; busy=0; all payload outputs 0; register file r1..r7 = 0. instr_ready_o=1 after reset deasserts.
- No internal arithmetic beyond sign extension; no flush input (scope: in-order, no branches).

Test Plan:
- Reset, then write r3=0x1234 and r4=0x0F0F via wb. Issue R-form func4=0, rd=5, rs1=3, rs2=4 -> next cycle ex_valid_o=1, rs1_data_o=0x1234, rs2_data_o=0x0F0F, rd_o=5, rd_wr_o=1, imm_en_o=0.
- I-form imm_en=1, imm5=0x1E, rs1=0 -> imm_o=0xFFFE, rs1_data_o=0; imm5=0x0F -> imm_o=0x000F.
- Issue writer rd=2, then a reader with rs1=2 -> instr_ready_o=0 until wb_en_i=1 with wb_rd_i=2 and wb_data_i=0xBEEF. Reader issues that same cycle with rs1_data_o=0xBEEF, and busy[2] stays clear.
- Hold ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> outputs unchanged and instr_ready_o=0. Release -> next instruction issues the same cycle.
- Write to r0 via wb, then issue rd=0 followed by rs1=0 -> no stall, rs1_data_o=0, rd_wr_o=0.
- Assert rst mid-stall with busy[2] set -> ex_valid_o=0 immediately. After release, a stalled rs1=2 reader issues at once with rs1_data_o=0.

Source files
------------

// File: rtl/decode_issue_if.sv
// rtl/decode_issue_if.sv - instruction, writeback and execute-side signals of the decode/issue stage
interface decode_issue_if #(
  parameter int XLEN = 16
);
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [15:0]     instr_i;

  logic            wb_en_i;
  logic [2:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;

  logic            ex_valid_o;
  logic            ex_ready_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic [XLEN-1:0] imm_o;
  logic            imm_en_o;
  logic [3:0]      func4_o;
  logic [2:0]      rd_o;
  logic            rd_wr_o;

  modport master (
    output instr_valid_i, instr_i, wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
    input  instr_ready_o, ex_valid_o, rs1_data_o, rs2_data_o, imm_o, imm_en_o,
           func4_o, rd_o, rd_wr_o
  );

  modport slave (
    input  instr_valid_i, instr_i, wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
    output instr_ready_o, ex_valid_o, rs1_data_o, rs2_data_o, imm_o, imm_en_o,
           func4_o, rd_o, rd_wr_o
  );
endinterface

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode, register read with writeback bypass, scoreboard hazard stall and issue register
module decode_issue #(
  parameter int XLEN  = 16,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          rst,
  decode_issue_if.slave bus
);

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] pending;

  logic            dec_imm_en;
  logic [3:0]      dec_func4;
  logic [2:0]      dec_rd;
  logic [2:0]      dec_rs1;
  logic [2:0]      dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] rd_val1;
  logic [XLEN-1:0] rd_val2;
  logic            stall;
  logic            ready;
  logic            issue;

  logic            ex_valid_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            imm_en_q;
  logic [3:0]      func4_q;
  logic [2:0]      rd_q;
  logic            rd_wr_q;

  assign dec_imm_en = bus.instr_i[15];
  assign dec_func4  = bus.instr_i[14:11];
  assign dec_rd     = bus.instr_i[10:8];
  assign dec_rs1    = bus.instr_i[7:5];
  assign dec_rs2    = bus.instr_i[4:2];
  assign dec_imm    = {{(XLEN-5){bus.instr_i[4]}}, bus.instr_i[4:0]};

  // A register being written back this cycle is no longer pending, and reads see the new value.
  assign wb_hit  = bus.wb_en_i ? (NREGS'(1) << bus.wb_rd_i) : '0;
  assign pending = busy & ~wb_hit;

  always_comb begin
    rd_val1 = rf[dec_rs1];
    rd_val2 = rf[dec_rs2];
    if (bus.wb_en_i && bus.wb_rd_i == dec_rs1) rd_val1 = bus.wb_data_i;
    if (bus.wb_en_i && bus.wb_rd_i == dec_rs2) rd_val2 = bus.wb_data_i;
    if (dec_rs1 == 3'd0) rd_val1 = '0;
    if (dec_rs2 == 3'd0) rd_val2 = '0;
  end

  assign stall = pending[dec_rs1]
              || (!dec_imm_en && pending[dec_rs2])
              || (dec_rd != 3'd0 && pending[dec_rd]);
  assign ready = !stall && (!ex_valid_q || bus.ex_ready_i);
  assign issue = bus.instr_valid_i && ready;

  // Set on issue is applied after the writeback clear so it wins on a collision.
  always_comb begin
    busy_next = busy;
    if (bus.wb_en_i) busy_next[bus.wb_rd_i] = 1'b0;
    if (issue && dec_rd != 3'd0) busy_next[dec_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      busy <= '0;
    end else begin
      if (bus.wb_en_i && bus.wb_rd_i != 3'd0) rf[bus.wb_rd_i] <= bus.wb_data_i;
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      imm_en_q   <= 1'b0;
      func4_q    <= '0;
      rd_q       <= '0;
      rd_wr_q    <= 1'b0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      rs1_data_q <= rd_val1;
      rs2_data_q <= rd_val2;
      imm_q      <= dec_imm;
      imm_en_q   <= dec_imm_en;
      func4_q    <= dec_func4;
      rd_q       <= dec_rd;
      rd_wr_q    <= (dec_rd != 3'd0);
    end else if (bus.ex_ready_i) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.instr_ready_o = ready;
  assign bus.ex_valid_o    = ex_valid_q;
  assign bus.rs1_data_o    = rs1_data_q;
  assign bus.rs2_data_o    = rs2_data_q;
  assign bus.imm_o         = imm_q;
  assign bus.imm_en_o      = imm_en_q;
  assign bus.func4_o       = func4_q;
  assign bus.rd_o          = rd_q;
  assign bus.rd_wr_o       = rd_wr_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed bench for decode_issue with a per-cycle reference model
module tb_decode_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  decode_issue_if bus ();

  decode_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: architectural registers, set of in-flight writers, and the issued instruction.
  logic [15:0] m_rf [8];
  bit          m_busy [8];
  bit          m_v;
  logic [15:0] m_rs1, m_rs2, m_imm;
  bit          m_immen, m_rdwr;
  logic [3:0]  m_f;
  logic [2:0]  m_rd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input int r);
    if (r == 0) return 16'h0;
    if (bus.wb_en_i && int'(bus.wb_rd_i) == r) return bus.wb_data_i;
    return m_rf[r];
  endfunction

  function automatic bit m_pending(input int r);
    return r != 0 && m_busy[r] && !(bus.wb_en_i && int'(bus.wb_rd_i) == r);
  endfunction

  function automatic bit m_ready();
    logic [15:0] w;
    bit hazard;
    w = bus.instr_i;
    hazard = m_pending(int'(w[7:5])) || (!w[15] && m_pending(int'(w[4:2]))) || m_pending(int'(w[10:8]));
    return !hazard && (!m_v || bus.ex_ready_i);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [15:0] w;
    bit iss;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_rf[i] = 16'h0;
        m_busy[i] = 1'b0;
      end
      m_v = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_immen = 0; m_rdwr = 0; m_f = 0; m_rd = 0;
    end else begin
      w = bus.instr_i;
      iss = bus.instr_valid_i && m_ready();
      if (iss) begin
        m_v     = 1;
        m_rs1   = m_read(int'(w[7:5]));
        m_rs2   = m_read(int'(w[4:2]));
        m_imm   = {{11{w[4]}}, w[4:0]};
        m_immen = w[15];
        m_f     = w[14:11];
        m_rd    = w[10:8];
        m_rdwr  = (w[10:8] != 3'd0);
      end else if (bus.ex_ready_i) begin
        m_v = 0;
      end
      if (bus.wb_en_i) begin
        m_busy[bus.wb_rd_i] = 1'b0;
        if (bus.wb_rd_i != 3'd0) m_rf[bus.wb_rd_i] = bus.wb_data_i;
      end
      if (iss && w[10:8] != 3'd0) m_busy[w[10:8]] = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("instr_ready", {15'h0, bus.instr_ready_o}, {15'h0, m_ready()});
    chk("ex_valid", {15'h0, bus.ex_valid_o}, {15'h0, m_v});
    if (m_v) begin
      chk("rs1_data", bus.rs1_data_o, m_rs1);
      chk("rs2_data", bus.rs2_data_o, m_rs2);
      chk("imm", bus.imm_o, m_imm);
      chk("imm_en", {15'h0, bus.imm_en_o}, {15'h0, m_immen});
      chk("func4", {12'h0, bus.func4_o}, {12'h0, m_f});
      chk("rd", {13'h0, bus.rd_o}, {13'h0, m_rd});
      chk("rd_wr", {15'h0, bus.rd_wr_o}, {15'h0, m_rdwr});
    end
  end

  function automatic logic [15:0] mk_r(input logic [3:0] f, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {1'b0, f, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] mk_i(input logic [3:0] f, input logic [2:0] rd, input logic [2:0] rs1, input logic [4:0] imm5);
    return {1'b1, f, rd, rs1, imm5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [2:0] r, input logic [15:0] d);
    bus.wb_en_i = en;
    bus.wb_rd_i = r;
    bus.wb_data_i = d;
  endtask

  task automatic drive(input logic v, input logic [15:0] w);
    bus.instr_valid_i = v;
    bus.instr_i = w;
  endtask

  initial begin
    drive(1'b0, 16'h0);
    wb(1'b0, 3'd0, 16'h0);
    bus.ex_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset ex_valid", {15'h0, bus.ex_valid_o}, 16'h0);
    chk("reset ready", {15'h0, bus.instr_ready_o}, 16'h1);
    chk("reset rs1_data", bus.rs1_data_o, 16'h0);

    wb(1'b1, 3'd3, 16'h1234); tick();
    wb(1'b1, 3'd4, 16'h0F0F); tick();
    wb(1'b0, 3'd0, 16'h0);

    drive(1'b1, mk_r(4'h0, 3'd5, 3'd3, 3'd4)); tick();
    chk("r-form valid", {15'h0, bus.ex_valid_o}, 16'h1);
    chk("r-form rs1", bus.rs1_data_o, 16'h1234);
    chk("r-form rs2", bus.rs2_data_o, 16'h0F0F);
    chk("r-form rd", {13'h0, bus.rd_o}, 16'h5);
    chk("r-form rd_wr", {15'h0, bus.rd_wr_o}, 16'h1);
    chk("r-form imm_en", {15'h0, bus.imm_en_o}, 16'h0);

    drive(1'b1, mk_i(4'h3, 3'd6, 3'd0, 5'h1E)); tick();
    chk("i-form neg imm", bus.imm_o, 16'hFFFE);
    chk("i-form rs1 r0", bus.rs1_data_o, 16'h0);
    chk("i-form imm_en", {15'h0, bus.imm_en_o}, 16'h1);
    drive(1'b1, mk_i(4'h3, 3'd7, 3'd0, 5'h0F)); tick();
    chk("i-form pos imm", bus.imm_o, 16'h000F);

    drive(1'b1, mk_r(4'h1, 3'd2, 3'd3, 3'd4)); tick();
    drive(1'b1, mk_r(4'h2, 3'd1, 3'd2, 3'd3)); #1;
    chk("raw stall", {15'h0, bus.instr_ready_o}, 16'h0);
    tick();
    chk("raw stall held", {15'h0, bus.instr_ready_o}, 16'h0);
    wb(1'b1, 3'd2, 16'hBEEF); #1;
    chk("raw release", {15'h0, bus.instr_ready_o}, 16'h1);
    tick();
    wb(1'b0, 3'd0, 16'h0);
    chk("raw bypass rs1", bus.rs1_data_o, 16'hBEEF);
    drive(1'b1, mk_r(4'h0, 3'd0, 3'd2, 3'd3)); #1;
    chk("busy2 clear", {15'h0, bus.instr_ready_o}, 16'h1);
    tick();
    chk("r2 readback", bus.rs1_data_o, 16'hBEEF);

    drive(1'b1, mk_r(4'h5, 3'd0, 3'd3, 3'd4)); tick();
    bus.ex_ready_i = 1'b0;
    drive(1'b1, mk_r(4'h6, 3'd0, 3'd4, 3'd3));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold ready", {15'h0, bus.instr_ready_o}, 16'h0);
      chk("hold func4", {12'h0, bus.func4_o}, 16'h5);
      chk("hold rs1", bus.rs1_data_o, 16'h1234);
      tick();
    end
    bus.ex_ready_i = 1'b1; #1;
    chk("release ready", {15'h0, bus.instr_ready_o}, 16'h1);
    tick();
    chk("release func4", {12'h0, bus.func4_o}, 16'h6);
    chk("release rs1", bus.rs1_data_o, 16'h0F0F);

    wb(1'b1, 3'd0, 16'hDEAD);
    drive(1'b1, mk_r(4'h7, 3'd0, 3'd3, 3'd4)); tick();
    chk("rd0 rd_wr", {15'h0, bus.rd_wr_o}, 16'h0);
    drive(1'b1, mk_r(4'h7, 3'd0, 3'd0, 3'd0)); #1;
    chk("rs1 r0 no stall", {15'h0, bus.instr_ready_o}, 16'h1);
    tick();
    wb(1'b0, 3'd0, 16'h0);
    chk("r0 reads zero", bus.rs1_data_o, 16'h0);

    drive(1'b1, mk_r(4'h1, 3'd2, 3'd3, 3'd4)); tick();
    drive(1'b1, mk_r(4'h2, 3'd1, 3'd2, 3'd3)); #1;
    chk("pre-reset stall", {15'h0, bus.instr_ready_o}, 16'h0);
    rst = 1'b1; #1;
    chk("async reset ex_valid", {15'h0, bus.ex_valid_o}, 16'h0);
    tick();
    rst = 1'b0; #1;
    chk("post-reset ready", {15'h0, bus.instr_ready_o}, 16'h1);
    tick();
    drive(1'b0, 16'h0);
    chk("post-reset valid", {15'h0, bus.ex_valid_o}, 16'h1);
    chk("post-reset rs1", bus.rs1_data_o, 16'h0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
